// File: rtl/tinyqv_peri_bus_arbiter.sv
// Two-master round-robin arbiter in front of the TinyQV peripheral slave port.
// Master 0 is the core data port, master 1 a secondary master (debug/DMA).
// One transaction is granted at a time. Reads are sequenced through ready and
// then read-complete. A read timeout keeps a dead peripheral from hanging a master.
`timescale 1ns/1ps

module tinyqv_peri_bus_arbiter #(
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic [10:0] m0_addr,
  input  logic [31:0] m0_data_in,
  input  logic [1:0]  m0_data_write_n,
  input  logic [1:0]  m0_data_read_n,
  output logic [31:0] m0_data_out,
  output logic        m0_data_ready,
  input  logic        m0_data_read_complete,

  input  logic [10:0] m1_addr,
  input  logic [31:0] m1_data_in,
  input  logic [1:0]  m1_data_write_n,
  input  logic [1:0]  m1_data_read_n,
  output logic [31:0] m1_data_out,
  output logic        m1_data_ready,
  input  logic        m1_data_read_complete,

  output logic [10:0] p_addr,
  output logic [31:0] p_data_in,
  output logic [1:0]  p_data_write_n,
  output logic [1:0]  p_data_read_n,
  input  logic [31:0] p_data_out,
  input  logic        p_data_ready,
  output logic        p_data_read_complete,

  output logic [1:0]  grant,
  output logic        timeout_flag
);

  // The counter only has to reach TIMEOUT_CYCLES-1, but it is kept at least 8 bits wide.
  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    WAIT_CPL = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             owner;
  logic             last;
  logic [CNT_W-1:0] counter;
  logic [31:0]      hold_data;
  logic             timeout_q;

  logic             m0_req;
  logic             m1_req;
  logic             any_req;
  logic             new_owner;

  logic [10:0]      own_addr;
  logic [31:0]      own_data;
  logic [1:0]       own_write_n;
  logic [1:0]       own_read_n;
  logic             own_cpl;
  logic             own_rd;
  logic             own_wr;
  logic             rd_timeout;
  logic             rd_done;
  logic [31:0]      rd_data;

  logic             own_ready;
  logic [31:0]      own_out;

  // Request decode, round-robin pick and the live mux of the owner's bus signals
  always_comb begin
    m0_req      = (m0_data_write_n != 2'b11) || (m0_data_read_n != 2'b11);
    m1_req      = (m1_data_write_n != 2'b11) || (m1_data_read_n != 2'b11);
    any_req     = m0_req || m1_req;
    new_owner   = (m0_req && m1_req) ? ~last : m1_req;

    own_addr    = owner ? m1_addr               : m0_addr;
    own_data    = owner ? m1_data_in            : m0_data_in;
    own_write_n = owner ? m1_data_write_n       : m0_data_write_n;
    own_read_n  = owner ? m1_data_read_n        : m0_data_read_n;
    own_cpl     = owner ? m1_data_read_complete : m0_data_read_complete;

    own_rd      = (own_read_n != 2'b11);
    own_wr      = (own_write_n != 2'b11);
    rd_timeout  = own_rd && !p_data_ready && (counter == CNT_LAST);
    rd_done     = own_rd && (p_data_ready || rd_timeout);
    rd_data     = p_data_ready ? p_data_out : TIMEOUT_DATA;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: grant from IDLE, finish or abort in ACCESS, wait for consumption
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (any_req) state_next = ACCESS;
      end
      ACCESS: begin
        if (!own_rd && !own_wr)                  state_next = IDLE;
        else if (own_rd && rd_done)              state_next = WAIT_CPL;
        else if (!own_rd && own_wr && p_data_ready) state_next = IDLE;
      end
      WAIT_CPL: begin
        if (own_cpl) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Owner/last bookkeeping, read timeout counter, read-data hold and sticky timeout flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner     <= 1'b0;
      last      <= 1'b1;
      counter   <= '0;
      hold_data <= 32'h0;
      timeout_q <= 1'b0;
    end else begin
      if (state == IDLE && any_req) begin
        owner   <= new_owner;
        last    <= new_owner;
        counter <= '0;
      end
      if (state == ACCESS && own_rd) begin
        if (counter != CNT_LAST) counter <= counter + 1'b1;
        if (rd_done)             hold_data <= rd_data;
        if (rd_timeout)          timeout_q <= 1'b1;
      end
    end
  end

  // Output decode: peripheral side from the owner, master side routed back to the owner only
  always_comb begin
    p_addr               = 11'h0;
    p_data_in            = 32'h0;
    p_data_write_n       = 2'b11;
    p_data_read_n        = 2'b11;
    p_data_read_complete = 1'b0;
    own_ready            = 1'b0;
    own_out              = 32'h0;
    grant                = 2'b00;

    case (state)
      ACCESS: begin
        p_addr         = own_addr;
        p_data_in      = own_data;
        p_data_write_n = own_write_n;
        p_data_read_n  = own_read_n;
        if (own_rd) begin
          own_ready = rd_done;
          own_out   = rd_done ? rd_data : 32'h0;
        end else begin
          own_ready = own_wr && p_data_ready;
        end
        grant = owner ? 2'b10 : 2'b01;
      end
      WAIT_CPL: begin
        p_data_read_complete = own_cpl;
        own_out              = hold_data;
        grant                = owner ? 2'b10 : 2'b01;
      end
      default: ;
    endcase

    m0_data_ready = !owner && own_ready;
    m1_data_ready =  owner && own_ready;
    m0_data_out   = owner ? 32'h0 : own_out;
    m1_data_out   = owner ? own_out : 32'h0;
    timeout_flag  = timeout_q;
  end

endmodule

// File: tb/tb_tinyqv_peri_bus_arbiter.sv
// Self-checking bench for tinyqv_peri_bus_arbiter: directed vector table,
// hand-written abort/reset sequences and randomized contention rounds against
// a transaction-level timing model.
`timescale 1ns/1ps

module tb_tinyqv_peri_bus_arbiter;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] m0_addr, m1_addr;
  logic [31:0] m0_data_in, m1_data_in;
  logic [1:0]  m0_data_write_n, m1_data_write_n;
  logic [1:0]  m0_data_read_n, m1_data_read_n;
  logic [31:0] m0_data_out, m1_data_out;
  logic        m0_data_ready, m1_data_ready;
  logic        m0_data_read_complete, m1_data_read_complete;
  logic [10:0] p_addr;
  logic [31:0] p_data_in;
  logic [1:0]  p_data_write_n, p_data_read_n;
  logic [31:0] p_data_out;
  logic        p_data_ready;
  logic        p_data_read_complete;
  logic [1:0]  grant;
  logic        timeout_flag;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rd;
    logic [1:0]  sz;
    logic [10:0] addr;
    logic [31:0] wdata;
    logic [31:0] pdata;
    int          dly;
    int          exp_cyc;
    logic [31:0] exp_data;
  } txn_t;

  typedef struct {
    logic [1:0] mask;
    txn_t       t0;
    txn_t       t1;
    logic       exp_flag;
  } vector_t;

  tinyqv_peri_bus_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_addr(m0_addr), .m0_data_in(m0_data_in), .m0_data_write_n(m0_data_write_n),
    .m0_data_read_n(m0_data_read_n), .m0_data_out(m0_data_out), .m0_data_ready(m0_data_ready),
    .m0_data_read_complete(m0_data_read_complete),
    .m1_addr(m1_addr), .m1_data_in(m1_data_in), .m1_data_write_n(m1_data_write_n),
    .m1_data_read_n(m1_data_read_n), .m1_data_out(m1_data_out), .m1_data_ready(m1_data_ready),
    .m1_data_read_complete(m1_data_read_complete),
    .p_addr(p_addr), .p_data_in(p_data_in), .p_data_write_n(p_data_write_n),
    .p_data_read_n(p_data_read_n), .p_data_out(p_data_out), .p_data_ready(p_data_ready),
    .p_data_read_complete(p_data_read_complete),
    .grant(grant), .timeout_flag(timeout_flag)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Hard stop in case the run wanders off
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int m, input logic [10:0] a, input logic [31:0] d,
                               input logic [1:0] wn, input logic [1:0] rn, input logic cpl);
    if (m == 0) begin
      m0_addr = a; m0_data_in = d; m0_data_write_n = wn; m0_data_read_n = rn; m0_data_read_complete = cpl;
    end else begin
      m1_addr = a; m1_data_in = d; m1_data_write_n = wn; m1_data_read_n = rn; m1_data_read_complete = cpl;
    end
  endtask

  task automatic allIdle();
    applyStimulus(0, 11'h0, 32'h0, 2'b11, 2'b11, 1'b0);
    applyStimulus(1, 11'h0, 32'h0, 2'b11, 2'b11, 1'b0);
    p_data_ready = 1'b0;
    p_data_out   = 32'h0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ready_of(input int m);
    return (m == 0) ? m0_data_ready : m1_data_ready;
  endfunction

  function automatic logic [31:0] out_of(input int m);
    return (m == 0) ? m0_data_out : m1_data_out;
  endfunction

  function automatic txn_t mk_txn(input logic rd, input logic [1:0] sz, input logic [10:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] pdata,
                                  input int dly, input int exp_cyc, input logic [31:0] exp_data);
    txn_t t;
    t.rd = rd; t.sz = sz; t.addr = addr; t.wdata = wdata; t.pdata = pdata;
    t.dly = dly; t.exp_cyc = exp_cyc; t.exp_data = exp_data;
    return t;
  endfunction

  function automatic vector_t mk_vec(input logic [1:0] mask, input txn_t t0, input txn_t t1, input logic flag);
    vector_t v;
    v.mask = mask; v.t0 = t0; v.t1 = t1; v.exp_flag = flag;
    return v;
  endfunction

  task automatic checkIdleBus(input string tag);
    checkOutput({tag, " grant"}, 32'(grant), 32'h0);
    checkOutput({tag, " p_write_n"}, 32'(p_data_write_n), 32'h3);
    checkOutput({tag, " p_read_n"}, 32'(p_data_read_n), 32'h3);
    checkOutput({tag, " p_cpl"}, 32'(p_data_read_complete), 32'h0);
    checkOutput({tag, " m0_ready"}, 32'(m0_data_ready), 32'h0);
    checkOutput({tag, " m1_ready"}, 32'(m1_data_ready), 32'h0);
    checkOutput({tag, " m0_out"}, m0_data_out, 32'h0);
    checkOutput({tag, " m1_out"}, m1_data_out, 32'h0);
  endtask

  // Runs one round starting from IDLE at cycle 0. Masters hold requests until
  // ready, read masters pulse read-complete the cycle after ready. The bench's
  // peripheral answers on access cycle index dly of the current owner.
  task automatic runRound(input vector_t v, input string tag);
    txn_t t[2];
    logic act[2], cpl_now[2], cpl_use[2];
    int   acc[2];
    int   last_cyc;
    int   o;
    logic r;
    t[0] = v.t0;
    t[1] = v.t1;
    last_cyc = 0;
    for (int m = 0; m < 2; m++) begin
      act[m] = v.mask[m]; cpl_now[m] = 1'b0; cpl_use[m] = 1'b0; acc[m] = -1;
      if (v.mask[m] && t[m].exp_cyc > last_cyc) last_cyc = t[m].exp_cyc;
    end
    last_cyc += 3;
    for (int k = 0; k <= last_cyc; k++) begin
      for (int m = 0; m < 2; m++) begin
        cpl_use[m] = cpl_now[m];
        cpl_now[m] = 1'b0;
        if (act[m])
          applyStimulus(m, t[m].addr, t[m].wdata, t[m].rd ? 2'b11 : t[m].sz,
                        t[m].rd ? t[m].sz : 2'b11, 1'b0);
        else
          applyStimulus(m, 11'h0, 32'h0, 2'b11, 2'b11, cpl_use[m]);
      end
      p_data_ready = 1'b0;
      p_data_out   = 32'h0;
      if (grant != 2'b00) begin
        o = grant[1] ? 1 : 0;
        if (act[o]) begin
          acc[o]++;
          if (acc[o] == t[o].dly) begin
            p_data_ready = 1'b1;
            p_data_out   = t[o].pdata;
          end
        end
      end
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        if (!v.mask[m]) begin
          checkOutput($sformatf("%s m%0d idle ready c%0d", tag, m, k), 32'(ready_of(m)), 32'h0);
          checkOutput($sformatf("%s m%0d idle out c%0d", tag, m, k), out_of(m), 32'h0);
        end else begin
          r = ready_of(m);
          checkOutput($sformatf("%s m%0d ready c%0d", tag, m, k), 32'(r), 32'(k == t[m].exp_cyc));
          if (r && act[m]) begin
            checkOutput($sformatf("%s m%0d grant", tag, m), 32'(grant), (m == 0) ? 32'h1 : 32'h2);
            checkOutput($sformatf("%s m%0d p_addr", tag, m), 32'(p_addr), 32'(t[m].addr));
            if (t[m].rd) begin
              checkOutput($sformatf("%s m%0d rdata", tag, m), out_of(m), t[m].exp_data);
              checkOutput($sformatf("%s m%0d p_read_n", tag, m), 32'(p_data_read_n), 32'(t[m].sz));
            end else begin
              checkOutput($sformatf("%s m%0d p_write_n", tag, m), 32'(p_data_write_n), 32'(t[m].sz));
              checkOutput($sformatf("%s m%0d p_data_in", tag, m), p_data_in, t[m].wdata);
            end
            act[m]     = 1'b0;
            cpl_now[m] = t[m].rd;
          end
          if (cpl_use[m]) begin
            checkOutput($sformatf("%s m%0d p_cpl", tag, m), 32'(p_data_read_complete), 32'h1);
            checkOutput($sformatf("%s m%0d wait p_read_n", tag, m), 32'(p_data_read_n), 32'h3);
            checkOutput($sformatf("%s m%0d hold data", tag, m), out_of(m), t[m].exp_data);
          end
        end
      end
      nextCycle();
    end
    allIdle();
    checkOutput({tag, " end grant"}, 32'(grant), 32'h0);
    checkOutput({tag, " timeout_flag"}, 32'(timeout_flag), 32'(v.exp_flag));
  endtask

  vector_t vec[8];
  txn_t    idle_t;
  vector_t rv;
  txn_t    tx[2];
  int      last_m;
  logic    flag_m;
  int      first, second, start;
  int      eff;

  initial begin
    idle_t = mk_txn(1'b0, 2'b11, 11'h0, 32'h0, 32'h0, 0, -1, 32'h0);
    vec[0] = mk_vec(2'b01, mk_txn(0, 2'b10, 11'h040, 32'h0000_00A5, 32'h0, 0, 1, 32'h0), idle_t, 1'b0);
    vec[1] = mk_vec(2'b10, idle_t, mk_txn(1, 2'b00, 11'h044, 32'h0, 32'h0000_005A, 2, 3, 32'h0000_005A), 1'b0);
    vec[2] = mk_vec(2'b11, mk_txn(0, 2'b10, 11'h100, 32'h1111_0000, 32'h0, 0, 1, 32'h0),
                           mk_txn(0, 2'b00, 11'h104, 32'h0000_0022, 32'h0, 0, 3, 32'h0), 1'b0);
    vec[3] = mk_vec(2'b11, mk_txn(0, 2'b01, 11'h108, 32'h0000_3333, 32'h0, 0, 1, 32'h0),
                           mk_txn(0, 2'b10, 11'h10C, 32'h4444_4444, 32'h0, 0, 3, 32'h0), 1'b0);
    vec[4] = mk_vec(2'b01, mk_txn(1, 2'b10, 11'h200, 32'h0, 32'h0BAD_0BAD, 10, 4, 32'hFFFF_FFFF), idle_t, 1'b1);
    vec[5] = mk_vec(2'b01, mk_txn(1, 2'b01, 11'h204, 32'h0, 32'h1234_5678, 1, 2, 32'h1234_5678), idle_t, 1'b1);
    vec[6] = mk_vec(2'b11, mk_txn(0, 2'b10, 11'h300, 32'hDEAD_BEEF, 32'h0, 1, 8, 32'h0),
                           mk_txn(1, 2'b00, 11'h304, 32'h0, 32'h0000_00C3, 3, 4, 32'h0000_00C3), 1'b1);
    vec[7] = mk_vec(2'b11, mk_txn(1, 2'b10, 11'h400, 32'h0, 32'h0404_0404, 2, 6, 32'h0404_0404),
                           mk_txn(1, 2'b01, 11'h408, 32'h0, 32'h0808_0808, 0, 1, 32'h0808_0808), 1'b1);

    rst_n = 1'b0;
    allIdle();
    nextCycle();
    nextCycle();
    checkIdleBus("reset");
    checkOutput("reset timeout_flag", 32'(timeout_flag), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) runRound(vec[i], $sformatf("vec%0d", i));

    // Abort: m1 read withdrawn after one ACCESS cycle, pending m0 write served next
    applyStimulus(1, 11'h044, 32'h0, 2'b11, 2'b00, 1'b0);
    @(negedge clk); checkOutput("abort c0 grant", 32'(grant), 32'h0);
    nextCycle();
    @(negedge clk);
    checkOutput("abort c1 grant", 32'(grant), 32'h2);
    checkOutput("abort c1 p_read_n", 32'(p_data_read_n), 32'h0);
    checkOutput("abort c1 p_addr", 32'(p_addr), 32'h044);
    nextCycle();
    applyStimulus(1, 11'h0, 32'h0, 2'b11, 2'b11, 1'b0);
    applyStimulus(0, 11'h080, 32'h0000_CAFE, 2'b10, 2'b11, 1'b0);
    @(negedge clk);
    checkOutput("abort c2 m1_ready", 32'(m1_data_ready), 32'h0);
    checkOutput("abort c2 m0_ready", 32'(m0_data_ready), 32'h0);
    checkOutput("abort c2 p_cpl", 32'(p_data_read_complete), 32'h0);
    nextCycle();
    @(negedge clk);
    checkOutput("abort c3 grant", 32'(grant), 32'h0);
    checkOutput("abort c3 m1_ready", 32'(m1_data_ready), 32'h0);
    checkOutput("abort c3 p_cpl", 32'(p_data_read_complete), 32'h0);
    nextCycle();
    p_data_ready = 1'b1;
    @(negedge clk);
    checkOutput("abort c4 grant", 32'(grant), 32'h1);
    checkOutput("abort c4 m0_ready", 32'(m0_data_ready), 32'h1);
    checkOutput("abort c4 p_addr", 32'(p_addr), 32'h080);
    checkOutput("abort c4 p_data_in", p_data_in, 32'h0000_CAFE);
    nextCycle();
    allIdle();
    @(negedge clk); checkOutput("abort c5 grant", 32'(grant), 32'h0);
    nextCycle();

    // Reset while m1 sits in WAIT_CPL
    applyStimulus(1, 11'h010, 32'h0, 2'b11, 2'b10, 1'b0);
    nextCycle();
    p_data_ready = 1'b1;
    p_data_out   = 32'h0000_0077;
    @(negedge clk);
    checkOutput("rstseq m1_ready", 32'(m1_data_ready), 32'h1);
    checkOutput("rstseq m1_out", m1_data_out, 32'h0000_0077);
    nextCycle();
    allIdle();
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rstseq wait grant", 32'(grant), 32'h2);
    checkOutput("rstseq wait hold", m1_data_out, 32'h0000_0077);
    checkOutput("rstseq wait p_read_n", 32'(p_data_read_n), 32'h3);
    checkOutput("rstseq sticky flag", 32'(timeout_flag), 32'h1);
    nextCycle();
    checkIdleBus("rstseq after");
    checkOutput("rstseq flag cleared", 32'(timeout_flag), 32'h0);
    rst_n = 1'b1;
    runRound(mk_vec(2'b10, idle_t, mk_txn(0, 2'b01, 11'h123, 32'h0000_BEEF, 32'h0, 1, 2, 32'h0), 1'b0), "post_rst");

    // Randomized rounds against a transaction-level timing model
    last_m = 1;
    flag_m = 1'b0;
    for (int i = 0; i < 60; i++) begin
      rv.mask = 2'($urandom_range(1, 3));
      for (int m = 0; m < 2; m++) begin
        tx[m].rd       = 1'($urandom);
        tx[m].sz       = 2'($urandom_range(0, 2));
        tx[m].addr     = 11'($urandom);
        tx[m].wdata    = $urandom;
        tx[m].pdata    = $urandom;
        tx[m].dly      = tx[m].rd ? $urandom_range(0, 6) : $urandom_range(0, 2);
        tx[m].exp_cyc  = -1;
        tx[m].exp_data = (tx[m].rd && tx[m].dly >= T) ? 32'hFFFF_FFFF : tx[m].pdata;
        if (rv.mask[m] && tx[m].rd && tx[m].dly >= T) flag_m = 1'b1;
      end
      if (rv.mask == 2'b11) first = (last_m == 0) ? 1 : 0;
      else                  first = rv.mask[1] ? 1 : 0;
      second = 1 - first;
      start = 1;
      eff = (tx[first].rd && tx[first].dly > T - 1) ? T - 1 : tx[first].dly;
      tx[first].exp_cyc = start + eff;
      last_m = first;
      if (rv.mask == 2'b11) begin
        start = tx[first].exp_cyc + (tx[first].rd ? 2 : 1) + 1;
        eff = (tx[second].rd && tx[second].dly > T - 1) ? T - 1 : tx[second].dly;
        tx[second].exp_cyc = start + eff;
        last_m = second;
      end
      rv.t0 = tx[0];
      rv.t1 = tx[1];
      rv.exp_flag = flag_m;
      runRound(rv, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tinyqv_peri_bus_arbiter.md
Name: tinyqv_peri_bus_arbiter

Overview:
Two-master arbiter in front of the `tinyQV_peripherals` slave port. Master 0 is the TinyQV core data port; master 1 is a secondary bus master, such as a debug or DMA engine. The block grants the single peripheral bus to one master per transaction using round-robin. It sequences the read handshake (ready, then read-complete) and applies a read timeout so a stalled peripheral cannot hang either master.

Parameters:
TIMEOUT_CYCLES, 64, maximum cycles a granted read may wait for peripheral data_ready before forced completion (must be >= 2).
TIMEOUT_DATA, 32'hFFFF_FFFF, read data returned to the master on timeout.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, active-low
m0_addr / m1_addr  in  11  master address
m0_data_in / m1_data_in  in  32  master write data
m0_data_write_n / m1_data_write_n  in  2  11 = none, 00/01/10 = 8/16/32-bit write
m0_data_read_n / m1_data_read_n  in  2  11 = none, 00/01/10 = 8/16/32-bit read
m0_data_out / m1_data_out  out  32  read data to master
m0_data_ready / m1_data_ready  out  1  transaction accepted / read data valid
m0_data_read_complete / m1_data_read_complete  in  1  master has consumed read data
p_addr  out  11  to peripheral block
p_data_in  out  32  to peripheral block
p_data_write_n  out  2  to peripheral block
p_data_read_n  out  2  to peripheral block
p_data_out  in  32  from peripheral block
p_data_ready  in  1  from peripheral block
p_data_read_complete  out  1  to peripheral block
grant  out  2  one-hot current owner, 00 when idle
timeout_flag  out  1  sticky; set on any read timeout

Behaviour:
- Single clock domain, `clk`. Reset is synchronous, active-low, `rst_n`. All state updates on posedge `clk`.
- Reset values:
  - state = IDLE, grant = 00, last = 1 (master 0 wins the first tie), timeout_flag = 0, counter = 0.
  - p_data_write_n = p_data_read_n = 11, p_data_read_complete = 0.
  - m*_data_ready = 0, m*_data_out = 0.
- Request definition: mX_req = (mX_data_write_n != 11) | (mX_data_read_n != 11). A master holds addr, data and size stable until it sees its ready.
- State IDLE:
  - Peripheral side idles: write_n/read_n = 11, addr and data = 0.
  - One requester: grant it.
  - Both requesting: grant the master != last.
  - On grant: latch owner, set last = owner, go to ACCESS. Owner is then fixed until return to IDLE.
- State ACCESS:
  - p_addr, p_data_in, p_data_write_n, p_data_read_n are driven combinationally from the owner's live inputs.
  - Write: the owner's data_ready = p_data_ready in the same cycle. When it is 1, go to IDLE. A write therefore completes 1 cycle after the request is first seen.
  - Read: counter increments each cycle.
    - p_data_ready = 1: owner data_out = p_data_out, owner data_ready = 1, capture data into a hold register, go to WAIT_CPL.
    - counter reaches TIMEOUT_CYCLES-1 without ready: owner data_ready = 1, data_out = TIMEOUT_DATA, timeout_flag <= 1, go to WAIT_CPL.
  - Abort: if the owner drops both read_n and write_n to 11 before ready, go to IDLE next cycle. No ready is given and no read-complete is issued.
- State WAIT_CPL:
  - p_data_read_n = 11, so the peripheral sees no repeated read.
  - Owner data_out keeps the hold register value; owner data_ready = 0.
  - p_data_read_complete = owner's data_read_complete, passed combinationally.
  - When that input is 1, go to IDLE.
- Non-owner master: data_ready = 0 and data_out = 0 at all times. Its request stays pending and is granted on the next IDLE cycle.
- IDLE lasts 1 cycle between back-to-back transactions, which gives fair alternation under contention. Under sustained contention each master gets every other transaction.
- A read-complete input from a non-owner is ignored.
- Reset mid-transaction: return to IDLE immediately, all outputs to reset values, no read-complete pulse, timeout_flag cleared.
- Counter is 8 bits (or wider if TIMEOUT_CYCLES > 255). It clears on every entry to ACCESS and never wraps.
- grant equals one-hot owner in ACCESS and WAIT_CPL, and 00 in IDLE.

Test Plan:
1. Reset, then m0 32-bit write addr 0x040, data 0xA5 (p_data_ready comb 1) -> grant = 01 the next cycle; p_data_write_n = 10, p_addr = 0x040 that cycle; m0_data_ready = 1 the same cycle; IDLE the following cycle.
2. m1 8-bit read of 0x044; peripheral returns ready 2 cycles into ACCESS with 0x5A -> m1_data_out = 0x0000005A with m1_data_ready pulse; p_data_read_n = 11 during WAIT_CPL; m1_data_read_complete pulse appears on p_data_read_complete; m0 outputs remain 0.
3. m0 and m1 both assert writes on the same cycle after reset -> m0 granted first, m1 granted after one IDLE cycle; repeated contention alternates 0,1,0,1.
4. m0 read, p_data_ready held 0, TIMEOUT_CYCLES = 4 -> m0_data_ready on the 4th ACCESS cycle with data 0xFFFFFFFF; timeout_flag = 1 and stays set through later normal reads.
5. m1 read granted, then m1 read_n set to 11 after 1 cycle -> IDLE next cycle, no m1_data_ready, no p_data_read_complete; a pending m0 request is granted next.
6. rst_n low during WAIT_CPL -> grant = 00, p_* idle, timeout_flag = 0 on the next cycle; a subsequent m1 request is granted normally.
